// File: rtl/counter_ctrl.sv
// counter_ctrl - sequencer for the 4-bit display counter datapath.
//
// Conditions the start/stop/load pushbuttons (2-flop synchronizer, debounce,
// rising-edge pulse), generates the prescaled count tick and runs the
// IDLE/RUN/PAUSE/DONE FSM. All strobes to the datapath are registered and
// last exactly one cycle.
//
// Optional feature: define COUNTER_CTRL_DOWN_EN to add the dir input and the
// cnt_dec output. In that build, dir=1 makes a tick count down toward 0.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start_btn  raw start button
//   stop_btn   raw stop button
//   load_btn   raw load button
//   set[3:0]   load value from switches
//   q[3:0]     current datapath count
//   mode_wrap  1 = wrap past terminal value, 0 = stop at it
//   dir        (COUNTER_CTRL_DOWN_EN only) 1 = count down
//   cnt_clr    one-cycle clear strobe
//   cnt_load   one-cycle load strobe
//   load_val   value to load, valid with cnt_load, held otherwise
//   cnt_inc    one-cycle increment strobe
//   cnt_dec    (COUNTER_CTRL_DOWN_EN only) one-cycle decrement strobe
//   running    high in RUN
//   done       high in DONE
//   state[1:0] IDLE=00, RUN=01, PAUSE=10, DONE=11
module counter_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int MAX_VAL   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       load_btn,
  input  logic [3:0] set,
  input  logic [3:0] q,
  input  logic       mode_wrap,
`ifdef COUNTER_CTRL_DOWN_EN
  input  logic       dir,
  output logic       cnt_dec,
`endif
  output logic       cnt_clr,
  output logic       cnt_load,
  output logic [3:0] load_val,
  output logic       cnt_inc,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0]  RELOAD  = PW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [3:0]     MAX4    = 4'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // ---------------- button conditioning ----------------
  logic [2:0] btn_raw;
  logic [2:0] btn_p;
  logic       start_p, stop_p, load_p;

  assign btn_raw = {load_btn, stop_btn, start_btn};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic           sync1_reg, sync2_reg;
    logic           level_reg, level_d_reg, pulse_reg;
    logic [DBW-1:0] db_cnt_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_reg   <= 1'b0;
        sync2_reg   <= 1'b0;
        level_reg   <= 1'b0;
        level_d_reg <= 1'b0;
        pulse_reg   <= 1'b0;
        db_cnt_reg  <= '0;
      end else begin
        sync1_reg   <= btn_raw[gi];
        sync2_reg   <= sync1_reg;
        level_d_reg <= level_reg;
        pulse_reg   <= level_reg & ~level_d_reg;
        // Count consecutive cycles of disagreement; any agreeing cycle
        // restarts the count, so bounces never reach acceptance.
        if (sync2_reg != level_reg) begin
          if (db_cnt_reg == DB_LAST) begin
            level_reg  <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end else begin
          db_cnt_reg <= '0;
        end
      end
    end

    assign btn_p[gi] = pulse_reg;
  end

  assign start_p = btn_p[0];
  assign stop_p  = btn_p[1];
  assign load_p  = btn_p[2];

  // ---------------- FSM, prescaler and strobes ----------------
  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          clr_reg, clr_next;
  logic          load_reg, load_next;
  logic          inc_reg, inc_next;
  logic [3:0]    load_val_reg, load_val_next;
  logic          tick;
  logic [3:0]    term_val;
`ifdef COUNTER_CTRL_DOWN_EN
  logic          dec_reg, dec_next;
  assign term_val = dir ? 4'd0 : MAX4;
`else
  assign term_val = MAX4;
`endif

  assign tick = (state_reg == RUN) && (presc_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      presc_reg    <= RELOAD;
      clr_reg      <= 1'b0;
      load_reg     <= 1'b0;
      inc_reg      <= 1'b0;
      load_val_reg <= 4'd0;
`ifdef COUNTER_CTRL_DOWN_EN
      dec_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      clr_reg      <= clr_next;
      load_reg     <= load_next;
      inc_reg      <= inc_next;
      load_val_reg <= load_val_next;
`ifdef COUNTER_CTRL_DOWN_EN
      dec_reg      <= dec_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    presc_next    = presc_reg;
    clr_next      = 1'b0;
    load_next     = 1'b0;
    inc_next      = 1'b0;
    load_val_next = load_val_reg;
`ifdef COUNTER_CTRL_DOWN_EN
    dec_next      = 1'b0;
`endif

    // Free-running countdown while in RUN; holds in every other state.
    if (state_reg == RUN) begin
      presc_next = (presc_reg == '0) ? RELOAD : presc_reg - 1'b1;
    end

    // Single prioritized event per cycle: load > stop > start > tick.
    if (load_p) begin
      load_next     = 1'b1;
      load_val_next = set;
      presc_next    = RELOAD;
      if (state_reg == DONE) state_next = IDLE;
    end else if (stop_p) begin
      case (state_reg)
        RUN:     state_next = PAUSE;
        PAUSE:   begin state_next = IDLE; clr_next = 1'b1; end
        DONE:    begin state_next = IDLE; clr_next = 1'b1; end
        default: state_next = state_reg;
      endcase
    end else if (start_p) begin
      case (state_reg)
        IDLE:    begin state_next = RUN; presc_next = RELOAD; end
        PAUSE:   state_next = RUN;  // resume from held prescaler value
        DONE:    begin state_next = RUN; presc_next = RELOAD; clr_next = 1'b1; end
        default: state_next = state_reg;
      endcase
    end else if (tick) begin
      if ((q != term_val) || mode_wrap) begin
`ifdef COUNTER_CTRL_DOWN_EN
        if (dir) dec_next = 1'b1;
        else     inc_next = 1'b1;
`else
        inc_next = 1'b1;
`endif
      end else begin
        state_next = DONE;
      end
    end
  end

  assign cnt_clr  = clr_reg;
  assign cnt_load = load_reg;
  assign cnt_inc  = inc_reg;
  assign load_val = load_val_reg;
`ifdef COUNTER_CTRL_DOWN_EN
  assign cnt_dec  = dec_reg;
`endif
  assign state    = state_reg;
  assign running  = (state_reg == RUN);
  assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl - directed self-checking bench for counter_ctrl
// (TICK_DIV=4, DB_CYCLES=3). A clean press driven just after edge E0 is
// accepted at E5, pulses after E6 and acts on the FSM at E7.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn, stop_btn, load_btn;
  logic [3:0] set, q;
  logic       mode_wrap;
  logic       cnt_clr, cnt_load, cnt_inc, running, done;
  logic [3:0] load_val;
  logic [1:0] state;
`ifdef COUNTER_CTRL_DOWN_EN
  logic       dir = 1'b0;
  logic       cnt_dec;
`endif

  int checks = 0;
  int passed = 0;
  int inc_total = 0;
  int excl_err = 0;
  int snap;

  counter_ctrl #(.TICK_DIV(4), .DB_CYCLES(3), .MAX_VAL(15)) dut (
    .clk(clk), .reset(reset),
    .start_btn(start_btn), .stop_btn(stop_btn), .load_btn(load_btn),
    .set(set), .q(q), .mode_wrap(mode_wrap),
`ifdef COUNTER_CTRL_DOWN_EN
    .dir(dir), .cnt_dec(cnt_dec),
`endif
    .cnt_clr(cnt_clr), .cnt_load(cnt_load), .load_val(load_val),
    .cnt_inc(cnt_inc), .running(running), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_inc) inc_total++;
    if ((int'(cnt_inc) + int'(cnt_clr) + int'(cnt_load)) > 1) excl_err++;
  end

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_strobes(input string tag, input int clr, input int ld, input int inc);
    chk({tag, "_clr"}, int'(cnt_clr), clr);
    chk({tag, "_load"}, int'(cnt_load), ld);
    chk({tag, "_inc"}, int'(cnt_inc), inc);
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; load_btn = 1'b0;
    set = 4'd0; q = 4'd0; mode_wrap = 1'b0;
    steps(3);
    chk("rst_state", int'(state), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_load_val", int'(load_val), 0);
    chk_strobes("rst", 0, 0, 0);
    reset = 1'b0;

    // Clean start press held ~10 cycles.
    start_btn = 1'b1;
    steps(6);
    chk("t1_pre_state", int'(state), 0);
    steps(1);
    chk("t1_state", int'(state), 1);
    chk("t1_running", int'(running), 1);
    snap = inc_total;
    steps(3);
    chk("t1_inc_e10", int'(cnt_inc), 0);
    start_btn = 1'b0;
    steps(1);
    chk("t1_inc_e11", int'(cnt_inc), 1);
    steps(1);
    chk("t1_inc_e12", int'(cnt_inc), 0);
    steps(3);
    chk("t1_inc_e15", int'(cnt_inc), 1);
    steps(1);
    chk("t1_inc_count", inc_total - snap, 2);
    steps(8);
    chk("t1_release_state", int'(state), 1);

    // Bouncing start: never accepted until stable for 3 cycles.
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    snap = inc_total;
    for (int i = 0; i < 8; i++) begin
      start_btn = (i % 2 == 0);
      steps(1);
    end
    chk("t2_bounce_state", int'(state), 0);
    start_btn = 1'b1;
    steps(6);
    chk("t2_pre_state", int'(state), 0);
    chk_strobes("t2_pre", 0, 0, 0);
    steps(1);
    chk("t2_state", int'(state), 1);
    chk("t2_no_inc", inc_total - snap, 0);

    // Terminal count with mode_wrap=0 -> DONE, no increment.
    q = 4'd15; mode_wrap = 1'b0;
    snap = inc_total;
    steps(3);
    chk("t3_pre_state", int'(state), 1);
    steps(1);
    chk("t3_state", int'(state), 3);
    chk("t3_done", int'(done), 1);
    chk("t3_running", int'(running), 0);
    chk("t3_inc", int'(cnt_inc), 0);
    steps(1);
    chk("t3_inc_count", inc_total - snap, 0);
    start_btn = 1'b0;
    steps(8);
    q = 4'd0;
    start_btn = 1'b1;
    steps(6);
    chk("t3_done_hold", int'(state), 3);
    steps(1);
    chk("t3_restart_state", int'(state), 1);
    chk_strobes("t3_restart", 1, 0, 0);
    q = 4'd15; mode_wrap = 1'b1;
    steps(1);
    chk("t3_clr_once", int'(cnt_clr), 0);

    // Terminal count with mode_wrap=1 -> increment, stay RUN.
    steps(2);
    chk("t4_inc_pre", int'(cnt_inc), 0);
    steps(1);
    chk("t4_inc", int'(cnt_inc), 1);
    chk("t4_state", int'(state), 1);
    steps(1);
    chk("t4_state_after", int'(state), 1);

    // Load in RUN.
    q = 4'd0; mode_wrap = 1'b0; start_btn = 1'b0;
    steps(8);
    set = 4'b1010; load_btn = 1'b1;
    steps(7);
    chk_strobes("t5_load", 0, 1, 0);
    chk("t5_load_val", int'(load_val), 10);
    chk("t5_state", int'(state), 1);
    set = 4'b0101;
    steps(3);
    chk_strobes("t5_gap", 0, 0, 0);
    chk("t5_load_val_hold", int'(load_val), 10);
    steps(1);
    chk("t5_inc_after_load", int'(cnt_inc), 1);

    // Load and stop in the same cycle: load wins.
    load_btn = 1'b0;
    steps(8);
    set = 4'b0011; load_btn = 1'b1; stop_btn = 1'b1;
    steps(7);
    chk_strobes("t6_both", 0, 1, 0);
    chk("t6_load_val", int'(load_val), 3);
    chk("t6_state", int'(state), 1);
    steps(1);
    chk("t6_state_after", int'(state), 1);
    load_btn = 1'b0; stop_btn = 1'b0;
    steps(8);
    chk("t6_pre_reset_state", int'(state), 1);

    // Reset mid-RUN.
    reset = 1'b1;
    steps(1);
    chk("t6_reset_state", int'(state), 0);
    chk("t6_reset_running", int'(running), 0);
    chk_strobes("t6_reset", 0, 0, 0);
    reset = 1'b0;
    steps(1);
    chk("t6_reset_no_inc", int'(cnt_inc), 0);

    // Pause and stop-from-pause.
    start_btn = 1'b1;
    steps(7);
    chk("t7_run", int'(state), 1);
    stop_btn = 1'b1;
    steps(7);
    chk("t7_pause", int'(state), 2);
    chk("t7_pause_running", int'(running), 0);
    snap = inc_total;
    stop_btn = 1'b0;
    steps(8);
    chk("t7_pause_hold", int'(state), 2);
    chk("t7_pause_no_inc", inc_total - snap, 0);
    stop_btn = 1'b1;
    steps(7);
    chk("t7_idle", int'(state), 0);
    chk_strobes("t7_stop_clr", 1, 0, 0);
    steps(1);
    chk("t7_clr_once", int'(cnt_clr), 0);

    chk("strobe_exclusive", excl_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
